vga_timing_480p: RTL and testbench

Raster timing generator for 640x480@60 VGA. It sits directly downstream of the 480p pixel clock generator: it runs on the pixel clock and is gated by that generator's lock flag. It produces registered hsync, vsync, display-enable, pixel coordinates and frame/line strobes for the pixel-colour and DVI/VGA output stages.

---
 rtl/vga_timing_480p_if.sv | 30 +++
 rtl/vga_timing_480p.sv | 92 +++++++++
 tb/tb_vga_timing_480p.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_480p_if.sv
// Raster timing bundle from vga_timing_480p to the pixel-colour and output stages.
// VGA_FRAME_COUNT_EN adds the 16-bit frame_count field.
interface vga_timing_480p_if #(
    parameter int unsigned COORD_W = 10
);
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic               line_start;
    logic               frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0]        frame_count;
`endif

    modport master (
        output hsync, vsync, de, sx, sy, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , output frame_count
`endif
    );

    modport slave (
        input hsync, vsync, de, sx, sy, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , input frame_count
`endif
    );
endinterface

// File: rtl/vga_timing_480p.sv
// 640x480@60 raster timing generator on the pixel clock, held in reset until the clock locks.
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter on the interface.
module vga_timing_480p #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter bit          SYNC_NEG = 1'b1,
    parameter int unsigned COORD_W  = 10
) (
    input  logic                 sysClock,
    input  logic                 reset,
    input  logic                 clk_pixel_locked,
    vga_timing_480p_if.master    vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_LO    = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_HI    = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_LO    = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_HI    = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic               rst_eff;
    logic [COORD_W-1:0] sx_q, sy_q, sx_nxt, sy_nxt;
    logic               hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic               hsync_nxt, vsync_nxt, de_nxt, line_start_nxt, frame_start_nxt;

    // Next counter position; reset parks at the last pixel so the following edge lands on (0,0).
    always_comb begin
        rst_eff = reset | ~clk_pixel_locked;
        sx_nxt  = sx_q + COORD_W'(1);
        sy_nxt  = sy_q;
        if (sx_q == H_LAST) begin
            sx_nxt = '0;
            sy_nxt = (sy_q == V_LAST) ? '0 : sy_q + COORD_W'(1);
        end
        if (rst_eff) begin
            sx_nxt = H_LAST;
            sy_nxt = V_LAST;
        end
    end

    // Decode the next position so every registered output describes the same (sx,sy).
    always_comb begin
        de_nxt          = (sx_nxt < H_ACT_C) && (sy_nxt < V_ACT_C);
        hsync_nxt       = ((sx_nxt >= HS_LO) && (sx_nxt < HS_HI)) ^ SYNC_NEG;
        vsync_nxt       = ((sy_nxt >= VS_LO) && (sy_nxt < VS_HI)) ^ SYNC_NEG;
        line_start_nxt  = (sx_nxt == '0);
        frame_start_nxt = (sx_nxt == '0) && (sy_nxt == '0);
    end

    always_ff @(posedge sysClock) begin
        sx_q          <= sx_nxt;
        sy_q          <= sy_nxt;
        de_q          <= de_nxt;
        hsync_q       <= hsync_nxt;
        vsync_q       <= vsync_nxt;
        line_start_q  <= line_start_nxt;
        frame_start_q <= frame_start_nxt;
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge sysClock) begin
        if (rst_eff) begin
            frame_count_q <= '0;
        end else if (frame_start_nxt) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign vga.frame_count = frame_count_q;
`endif

    assign vga.sx          = sx_q;
    assign vga.sy          = sy_q;
    assign vga.de          = de_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_480p.sv
// Scoreboard bench: a full-size 480p instance plus a tiny-raster, active-high-sync instance
// that makes vertical timing, frame intervals and the reset-at-wrap case reachable quickly.
module tb_vga_timing_480p;
    typedef struct {
        bit hs, vs, de, ls, fs, rst;
        int sx, sy, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_pixel_locked = 1'b0;

    int total = 0;
    int bad = 0;

    exp_t qa[$];
    exp_t qb[$];

    int a_sx = 799, a_sy = 524, a_fc = 0;
    int b_sx = 7,   b_sy = 6,   b_fc = 0;

    int a_hs_cnt = 0, a_de_cnt = 0, a_ls_cnt = 0;
    bit b_prev_ok = 1'b0;
    int b_cyc = 0, b_de_cnt = 0, b_vs_cnt = 0;

    vga_timing_480p_if #(.COORD_W(10)) a_if ();
    vga_timing_480p_if #(.COORD_W(10)) b_if ();

    vga_timing_480p u_a (
        .sysClock         (clk),
        .reset            (reset),
        .clk_pixel_locked (clk_pixel_locked),
        .vga              (a_if)
    );

    // 8 x 7 raster: hsync sx 5..6, vsync sy 4..5, active-high syncs.
    vga_timing_480p #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_NEG (1'b0), .COORD_W (10)
    ) u_b (
        .sysClock         (clk),
        .reset            (reset),
        .clk_pixel_locked (clk_pixel_locked),
        .vga              (b_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t dec(input int sx, input int sy, input int ha, input int hs0,
                                 input int hs1, input int va, input int vs0, input int vs1,
                                 input bit neg, input int fc, input bit r);
        exp_t e;
        bit ha_act, va_act;
        ha_act = (sx >= hs0) && (sx < hs1);
        va_act = (sy >= vs0) && (sy < vs1);
        e.sx  = sx;
        e.sy  = sy;
        e.de  = (sx < ha) && (sy < va);
        e.hs  = neg ? !ha_act : ha_act;
        e.vs  = neg ? !va_act : va_act;
        e.ls  = (sx == 0);
        e.fs  = (sx == 0) && (sy == 0);
        e.fc  = fc;
        e.rst = r;
        return e;
    endfunction

    // Drive one edge and push the expected post-edge outputs of both instances.
    task automatic step(input bit r, input bit lk);
        bit e;
        @(negedge clk);
        reset = r;
        clk_pixel_locked = lk;
        @(posedge clk);
        e = r || !lk;
        if (e) begin
            a_sx = 799; a_sy = 524; a_fc = 0;
            b_sx = 7;   b_sy = 6;   b_fc = 0;
        end else begin
            if (a_sx == 799) begin
                a_sx = 0;
                a_sy = (a_sy == 524) ? 0 : a_sy + 1;
            end else a_sx++;
            if (a_sx == 0 && a_sy == 0) a_fc = (a_fc + 1) & 'hFFFF;
            if (b_sx == 7) begin
                b_sx = 0;
                b_sy = (b_sy == 6) ? 0 : b_sy + 1;
            end else b_sx++;
            if (b_sx == 0 && b_sy == 0) b_fc = (b_fc + 1) & 'hFFFF;
        end
        qa.push_back(dec(a_sx, a_sy, 640, 656, 752, 480, 490, 492, 1'b1, a_fc, e));
        qb.push_back(dec(b_sx, b_sy, 4, 5, 7, 3, 4, 6, 1'b0, b_fc, e));
    endtask

    // Monitor for the full-size instance.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            exp_t e;
            e = qa.pop_front();
            chk("a_sx", int'(a_if.sx), e.sx);
            chk("a_sy", int'(a_if.sy), e.sy);
            chk("a_de", int'(a_if.de), int'(e.de));
            chk("a_hsync", int'(a_if.hsync), int'(e.hs));
            chk("a_vsync", int'(a_if.vsync), int'(e.vs));
            chk("a_line_start", int'(a_if.line_start), int'(e.ls));
            chk("a_frame_start", int'(a_if.frame_start), int'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
            chk("a_frame_count", int'(a_if.frame_count), e.fc);
`endif
            if (!e.rst && a_if.sy == 10'd0) begin
                if (a_if.hsync == 1'b0) a_hs_cnt++;
                if (a_if.de == 1'b1) a_de_cnt++;
            end
            if (!e.rst && a_if.line_start == 1'b1) a_ls_cnt++;
        end
    end

    // Monitor for the tiny instance, with per-frame interval and occupancy checks.
    always @(negedge clk) begin
        if (qb.size() > 0) begin
            exp_t e;
            e = qb.pop_front();
            chk("b_sx", int'(b_if.sx), e.sx);
            chk("b_sy", int'(b_if.sy), e.sy);
            chk("b_de", int'(b_if.de), int'(e.de));
            chk("b_hsync", int'(b_if.hsync), int'(e.hs));
            chk("b_vsync", int'(b_if.vsync), int'(e.vs));
            chk("b_line_start", int'(b_if.line_start), int'(e.ls));
            chk("b_frame_start", int'(b_if.frame_start), int'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
            chk("b_frame_count", int'(b_if.frame_count), e.fc);
`endif
            if (e.rst) begin
                b_prev_ok = 1'b0;
                b_cyc = 0; b_de_cnt = 0; b_vs_cnt = 0;
            end else begin
                if (b_if.frame_start == 1'b1) begin
                    if (b_prev_ok) begin
                        chk("b_frame_interval", b_cyc, 56);
                        chk("b_de_per_frame", b_de_cnt, 12);
                        chk("b_vsync_cycles", b_vs_cnt, 16);
                    end
                    b_prev_ok = 1'b1;
                    b_cyc = 0; b_de_cnt = 0; b_vs_cnt = 0;
                end
                b_cyc++;
                if (b_if.de == 1'b1) b_de_cnt++;
                if (b_if.vsync == 1'b1) b_vs_cnt++;
            end
        end
    end

    initial begin
        int guard;
        // Held in reset with and without lock.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Release: first edge lands on (0,0); run through line 0 into line 1 at sx=300.
        for (int i = 0; i < 1101; i++) step(1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("a_hsync_cycles_line0", a_hs_cnt, 96);
        chk("a_de_cycles_line0", a_de_cnt, 640);
        chk("a_line_start_count", a_ls_cnt, 2);

        // Lock loss mid-line for 5 cycles, then recovery at (0,0).
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        // Bring the tiny raster to its wrap point and assert reset there.
        guard = 0;
        while (!(b_sx == 7 && b_sy == 6) && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        if (guard >= 100) chk("b_reach_wrap", 0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1);

        guard = 0;
        while ((qa.size() > 0 || qb.size() > 0) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (qa.size() > 0 || qb.size() > 0) chk("queue_drain", qa.size() + qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
